vc_ctrl: RTL and testbench

//   Victim-cache controller for the 8-entry fully associative victim cache (VC) behind L1.

---
 rtl/vc_pkg.sv | 23 ++
 rtl/vc_tag_match.sv | 37 +++
 rtl/vc_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_vc_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared types and sizing for the victim-cache controller.
package vc_pkg;

   localparam int TAG_W    = 27;
   localparam int LINE_W   = 256;
   localparam int ENTRIES  = 8;
   localparam int VC_IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      RESP   = 2'd2,
      WB     = 2'd3
   } vc_state_e;

   typedef struct packed {
      logic              valid;
      logic              dirty;
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] data;
   } vc_entry_t;

endpackage

// File: rtl/vc_tag_match.sv
// Parallel tag compare across all VC entries, plus priority encoders for the
// matching entry and the first free entry (lowest index wins in both).
module vc_tag_match
   import vc_pkg::*;
(
   input  logic [ENTRIES-1:0]            valid,
   input  logic [ENTRIES-1:0][TAG_W-1:0] tags,
   input  logic [TAG_W-1:0]              req_tag,
   output logic                          hit,
   output logic [VC_IDX_W-1:0]           hit_idx,
   output logic                          any_invalid,
   output logic [VC_IDX_W-1:0]           first_invalid_idx
);

   // Scan high-to-low so the last (lowest) index found overrides earlier ones.
   always_comb begin
      hit               = 1'b0;
      hit_idx           = '0;
      any_invalid       = 1'b0;
      first_invalid_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid[i] && (tags[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = VC_IDX_W'(i);
         end else begin
            hit = hit;
         end
         if (!valid[i]) begin
            any_invalid       = 1'b1;
            first_invalid_idx = VC_IDX_W'(i);
         end else begin
            any_invalid = any_invalid;
         end
      end
   end

endmodule

// File: rtl/vc_ctrl.sv
// Victim-cache controller: takes an L1 miss (optionally with an L1 victim),
// probes the 8-entry VC, swaps on hit, inserts on miss, and forwards a
// displaced dirty line toward L2.
module vc_ctrl
   import vc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [TAG_W-1:0]    req_tag,
   input  logic                req_has_vic,
   input  logic [TAG_W-1:0]    vic_tag,
   input  logic [LINE_W-1:0]   vic_data,
   input  logic                vic_dirty,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_hit,
   output logic [LINE_W-1:0]   rsp_data,
   output logic                rsp_dirty,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [TAG_W-1:0]    wb_tag,
   output logic [LINE_W-1:0]   wb_data,
   output logic                acc_en,
   output logic [VC_IDX_W-1:0] acc_idx,
   input  logic [VC_IDX_W-1:0] lru_idx
);

   vc_state_e                      state_q, state_d;
   logic                           req_ready_q, req_ready_d;
   logic                           rsp_valid_q, rsp_valid_d;
   logic                           rsp_hit_q, rsp_hit_d;
   logic                           rsp_dirty_q, rsp_dirty_d;
   logic [LINE_W-1:0]              rsp_data_q, rsp_data_d;
   logic                           wb_valid_q, wb_valid_d;
   logic                           wb_pend_q, wb_pend_d;
   logic [TAG_W-1:0]               wb_tag_q, wb_tag_d;
   logic [LINE_W-1:0]              wb_data_q, wb_data_d;
   logic [TAG_W-1:0]               lk_tag_q, lk_tag_d;
   vc_entry_t                      vic_q, vic_d;
   logic [ENTRIES-1:0]             valid_q, valid_d;
   logic [ENTRIES-1:0]             dirty_q, dirty_d;
   logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
   logic [ENTRIES-1:0][LINE_W-1:0] data_q, data_d;

   logic                           hit_s;
   logic [VC_IDX_W-1:0]            hit_idx_s;
   logic                           any_inv_s;
   logic [VC_IDX_W-1:0]            first_inv_s;
   logic [VC_IDX_W-1:0]            target_s;
   logic                           wr_en_s;
   logic [VC_IDX_W-1:0]            wr_idx_s;
   logic                           acc_en_s;
   logic [VC_IDX_W-1:0]            acc_idx_s;

   vc_tag_match u_match (
      .valid             (valid_q),
      .tags              (tag_q),
      .req_tag           (lk_tag_q),
      .hit               (hit_s),
      .hit_idx           (hit_idx_s),
      .any_invalid       (any_inv_s),
      .first_invalid_idx (first_inv_s)
   );

   // Next-state, array update and output computation for every FSM state.
   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_dirty_d = rsp_dirty_q;
      rsp_data_d  = rsp_data_q;
      wb_valid_d  = wb_valid_q;
      wb_pend_d   = wb_pend_q;
      wb_tag_d    = wb_tag_q;
      wb_data_d   = wb_data_q;
      lk_tag_d    = lk_tag_q;
      vic_d       = vic_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      tag_d       = tag_q;
      data_d      = data_q;
      wr_en_s     = 1'b0;
      wr_idx_s    = '0;
      acc_en_s    = 1'b0;
      acc_idx_s   = '0;
      // Miss insertion prefers a free slot; the PLRU choice is only used when full.
      target_s    = any_inv_s ? first_inv_s : lru_idx;

      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_ready_q && req_valid) begin
               lk_tag_d    = req_tag;
               vic_d       = '{valid: req_has_vic, dirty: vic_dirty, tag: vic_tag, data: vic_data};
               req_ready_d = 1'b0;
               state_d     = LOOKUP;
            end else begin
               state_d = IDLE;
            end
         end
         LOOKUP: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_hit_d   = hit_s;
            if (hit_s) begin
               rsp_data_d  = data_q[hit_idx_s];
               rsp_dirty_d = dirty_q[hit_idx_s];
               if (vic_q.valid) begin
                  wr_en_s  = 1'b1;
                  wr_idx_s = hit_idx_s;
               end else begin
                  // Line moves to L1 with nothing to swap in: drop it from the VC.
                  valid_d[hit_idx_s] = 1'b0;
                  dirty_d[hit_idx_s] = 1'b0;
               end
            end else begin
               rsp_data_d  = '0;
               rsp_dirty_d = 1'b0;
               if (vic_q.valid) begin
                  wr_en_s  = 1'b1;
                  wr_idx_s = target_s;
                  if (valid_q[target_s] && dirty_q[target_s]) begin
                     wb_pend_d = 1'b1;
                     wb_tag_d  = tag_q[target_s];
                     wb_data_d = data_q[target_s];
                  end else begin
                     wb_pend_d = 1'b0;
                  end
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            if (wr_en_s) begin
               valid_d[wr_idx_s] = 1'b1;
               dirty_d[wr_idx_s] = vic_q.dirty;
               tag_d[wr_idx_s]   = vic_q.tag;
               data_d[wr_idx_s]  = vic_q.data;
               acc_en_s          = 1'b1;
               acc_idx_s         = wr_idx_s;
            end else begin
               acc_en_s = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_hit_d   = 1'b0;
               rsp_dirty_d = 1'b0;
               rsp_data_d  = '0;
               if (wb_pend_q) begin
                  wb_valid_d = 1'b1;
                  state_d    = WB;
               end else begin
                  req_ready_d = 1'b1;
                  state_d     = IDLE;
               end
            end else begin
               state_d = RESP;
            end
         end
         WB: begin
            if (wb_ready) begin
               wb_valid_d  = 1'b0;
               wb_pend_d   = 1'b0;
               wb_tag_d    = '0;
               wb_data_d   = '0;
               req_ready_d = 1'b1;
               state_d     = IDLE;
            end else begin
               state_d = WB;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state, entry flags and registered outputs; reset empties the VC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_dirty_q <= 1'b0;
         rsp_data_q  <= '0;
         wb_valid_q  <= 1'b0;
         wb_pend_q   <= 1'b0;
         wb_tag_q    <= '0;
         wb_data_q   <= '0;
         lk_tag_q    <= '0;
         vic_q       <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_dirty_q <= rsp_dirty_d;
         rsp_data_q  <= rsp_data_d;
         wb_valid_q  <= wb_valid_d;
         wb_pend_q   <= wb_pend_d;
         wb_tag_q    <= wb_tag_d;
         wb_data_q   <= wb_data_d;
         lk_tag_q    <= lk_tag_d;
         vic_q       <= vic_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Tag/data storage; contents are qualified by valid_q so no reset is needed.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_dirty = rsp_dirty_q;
   assign rsp_data  = rsp_data_q;
   assign wb_valid  = wb_valid_q;
   assign wb_tag    = wb_tag_q;
   assign wb_data   = wb_data_q;
   // The PLRU must see the access during LOOKUP itself, so this is a state decode.
   assign acc_en    = acc_en_s;
   assign acc_idx   = acc_idx_s;

endmodule

// File: tb/tb_vc_ctrl.sv
// Scoreboard bench for vc_ctrl: a behavioural VC model predicts each response,
// write-back and PLRU access; scenario tasks compare DUT observations against it.
module tb_vc_ctrl;
   import vc_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                req_valid = 1'b0, req_ready;
   logic [TAG_W-1:0]    req_tag = '0;
   logic                req_has_vic = 1'b0;
   logic [TAG_W-1:0]    vic_tag = '0;
   logic [LINE_W-1:0]   vic_data = '0;
   logic                vic_dirty = 1'b0;
   logic                rsp_valid, rsp_ready = 1'b0, rsp_hit, rsp_dirty;
   logic [LINE_W-1:0]   rsp_data;
   logic                wb_valid, wb_ready = 1'b0;
   logic [TAG_W-1:0]    wb_tag;
   logic [LINE_W-1:0]   wb_data;
   logic                acc_en;
   logic [VC_IDX_W-1:0] acc_idx;
   logic [VC_IDX_W-1:0] lru_idx = '0;

   vc_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
      .req_has_vic(req_has_vic), .vic_tag(vic_tag), .vic_data(vic_data), .vic_dirty(vic_dirty),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
      .rsp_dirty(rsp_dirty), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
      .wb_data(wb_data), .acc_en(acc_en), .acc_idx(acc_idx), .lru_idx(lru_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              hit;
      logic [LINE_W-1:0] data;
      logic              dirty;
      logic              wb;
      logic [TAG_W-1:0]  wb_tag;
      logic [LINE_W-1:0] wb_data;
      logic              acc_en;
      logic [2:0]        acc_idx;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   // reference VC contents
   logic              m_valid [ENTRIES];
   logic              m_dirty [ENTRIES];
   logic [TAG_W-1:0]  m_tag   [ENTRIES];
   logic [LINE_W-1:0] m_data  [ENTRIES];

   // observations filled in by transact
   logic              obs_timeout, obs_stable, obs_lk_rsp, obs_lk_ready, obs_rsp_n2;
   logic              obs_acc_en, obs_hit, obs_dirty, obs_wb_valid, obs_end_ready;
   logic [2:0]        obs_acc_idx;
   logic [LINE_W-1:0] obs_data, obs_wb_data;
   logic [TAG_W-1:0]  obs_wb_tag;

   int   acc_cnt = 0;
   logic acc_bad = 1'b0;

   // count PLRU pulses and flag any nonzero index outside a pulse
   always @(posedge clk) begin
      if (acc_en === 1'b1) acc_cnt <= acc_cnt + 1;
      if (rst === 1'b1 && acc_en === 1'b0 && acc_idx !== 3'd0) acc_bad <= 1'b1;
   end

   function automatic logic [LINE_W-1:0] line_of(input logic [TAG_W-1:0] t);
      logic [LINE_W-1:0] d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = {5'd0, t} ^ (32'h9E37_79B9 * 32'(k + 1));
      return d;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < ENTRIES; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
   endfunction

   function automatic exp_t model(input logic [TAG_W-1:0] t, input logic hv, input logic [TAG_W-1:0] vt,
                                  input logic [LINE_W-1:0] vd, input logic vdy, input logic [2:0] lru);
      exp_t e;
      int h, tg;
      e = '{hit: 1'b0, data: '0, dirty: 1'b0, wb: 1'b0, wb_tag: '0, wb_data: '0, acc_en: 1'b0, acc_idx: 3'd0};
      h = -1;
      for (int i = ENTRIES - 1; i >= 0; i--) if (m_valid[i] && m_tag[i] == t) h = i;
      if (h >= 0) begin
         e.hit = 1'b1; e.data = m_data[h]; e.dirty = m_dirty[h];
         if (hv) begin
            m_tag[h] = vt; m_data[h] = vd; m_dirty[h] = vdy;
            e.acc_en = 1'b1; e.acc_idx = 3'(h);
         end else begin
            m_valid[h] = 1'b0; m_dirty[h] = 1'b0;
         end
      end else if (hv) begin
         tg = -1;
         for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) tg = i;
         if (tg < 0) tg = int'(lru);
         if (m_valid[tg] && m_dirty[tg]) begin
            e.wb = 1'b1; e.wb_tag = m_tag[tg]; e.wb_data = m_data[tg];
         end
         m_valid[tg] = 1'b1; m_dirty[tg] = vdy; m_tag[tg] = vt; m_data[tg] = vd;
         e.acc_en = 1'b1; e.acc_idx = 3'(tg);
      end
      return e;
   endfunction

   // Drive one request through the whole handshake sequence and record observations.
   // rs/ws: cycles to hold rsp_ready/wb_ready low; ws < 0 leaves the write-back pending.
   task automatic transact(input logic [TAG_W-1:0] t, input logic hv, input logic [TAG_W-1:0] vt,
                           input logic vdy, input int rs, input int ws);
      int n;
      exp_q.push_back(model(t, hv, vt, line_of(vt), vdy, lru_idx));
      obs_timeout = 1'b0; obs_stable = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (req_ready !== 1'b1) obs_timeout = 1'b1;
      req_tag = t; req_has_vic = hv; vic_tag = vt; vic_data = line_of(vt); vic_dirty = vdy;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_tag = TAG_W'($urandom); req_has_vic = 1'b1;
      vic_tag = TAG_W'($urandom); vic_dirty = 1'b1;
      obs_lk_rsp = rsp_valid; obs_lk_ready = req_ready; obs_acc_en = acc_en; obs_acc_idx = acc_idx;
      @(posedge clk); #1;
      obs_rsp_n2 = rsp_valid;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (rsp_valid !== 1'b1) obs_timeout = 1'b1;
      obs_hit = rsp_hit; obs_data = rsp_data; obs_dirty = rsp_dirty;
      for (int i = 0; i < rs; i++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_hit !== obs_hit || rsp_data !== obs_data ||
             rsp_dirty !== obs_dirty || req_ready !== 1'b0 || wb_valid !== 1'b0) obs_stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      obs_wb_valid = wb_valid; obs_wb_tag = wb_tag; obs_wb_data = wb_data;
      if (wb_valid === 1'b1 && ws >= 0) begin
         for (int i = 0; i < ws; i++) begin
            @(posedge clk); #1;
            if (wb_valid !== 1'b1 || wb_tag !== obs_wb_tag || wb_data !== obs_wb_data ||
                req_ready !== 1'b0 || rsp_valid !== 1'b0) obs_stable = 1'b0;
         end
         wb_ready = 1'b1;
         @(posedge clk); #1;
         wb_ready = 1'b0;
      end
      obs_end_ready = req_ready;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0b want 0", req_ready); else n_pass++;
      n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); else n_pass++;
      n_chk++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %0b want 0", wb_valid); else n_pass++;
      n_chk++; if (acc_en !== 1'b0 || acc_idx !== 3'd0) $display("FAIL rst_acc: got %0b/%0d want 0/0", acc_en, acc_idx); else n_pass++;
      @(negedge clk); rst = 1'b1; model_clear();
      @(posedge clk); #1;
      n_chk++; if (req_ready !== 1'b1) $display("FAIL rel_req_ready: got %0b want 1", req_ready); else n_pass++;
   endtask

   task automatic test_empty_miss();
      exp_t e;
      int a0;
      a0 = acc_cnt;
      transact(27'h10, 1'b0, 27'h0, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_timeout !== 1'b0) $display("FAIL em_timeout: got %0b want 0", obs_timeout); else n_pass++;
      n_chk++; if (obs_lk_rsp !== 1'b0 || obs_lk_ready !== 1'b0) $display("FAIL em_lookup: got rsp_valid=%0b req_ready=%0b want 0/0", obs_lk_rsp, obs_lk_ready); else n_pass++;
      n_chk++; if (obs_rsp_n2 !== 1'b1) $display("FAIL em_latency: got rsp_valid=%0b want 1", obs_rsp_n2); else n_pass++;
      n_chk++; if (obs_hit !== e.hit || obs_data !== e.data || obs_dirty !== e.dirty) $display("FAIL em_rsp: got hit=%0b data=%0h dirty=%0b want %0b/%0h/%0b", obs_hit, obs_data, obs_dirty, e.hit, e.data, e.dirty); else n_pass++;
      n_chk++; if (acc_cnt - a0 !== 0) $display("FAIL em_acc: got %0d pulses want 0", acc_cnt - a0); else n_pass++;
      n_chk++; if (obs_wb_valid !== 1'b0) $display("FAIL em_wb: got %0b want 0", obs_wb_valid); else n_pass++;
      n_chk++; if (obs_end_ready !== 1'b1) $display("FAIL em_ready: got %0b want 1", obs_end_ready); else n_pass++;
   endtask

   task automatic test_fill();
      exp_t e;
      int a0;
      a0 = acc_cnt;
      for (int i = 0; i < ENTRIES; i++) begin
         transact(27'h100 + 27'(i), 1'b1, 27'(i + 1), 1'b0, 0, 0);
         e = exp_q.pop_front();
         n_chk++; if (obs_acc_en !== 1'b1 || obs_acc_idx !== 3'(i) || obs_acc_idx !== e.acc_idx) $display("FAIL fill_acc[%0d]: got %0b/%0d want 1/%0d", i, obs_acc_en, obs_acc_idx, i); else n_pass++;
         n_chk++; if (obs_hit !== e.hit || obs_data !== e.data || obs_wb_valid !== e.wb) $display("FAIL fill_rsp[%0d]: got hit=%0b wb=%0b want %0b/%0b", i, obs_hit, obs_wb_valid, e.hit, e.wb); else n_pass++;
      end
      n_chk++; if (acc_cnt - a0 !== 8) $display("FAIL fill_pulses: got %0d want 8", acc_cnt - a0); else n_pass++;
   endtask

   task automatic test_hit_swap();
      exp_t e;
      transact(27'h3, 1'b1, 27'h20, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hit !== 1'b1 || obs_data !== line_of(27'h3) || obs_data !== e.data) $display("FAIL swap_rsp: got hit=%0b data=%0h want 1/%0h", obs_hit, obs_data, e.data); else n_pass++;
      n_chk++; if (obs_acc_en !== 1'b1 || obs_acc_idx !== 3'd2) $display("FAIL swap_acc: got %0b/%0d want 1/2", obs_acc_en, obs_acc_idx); else n_pass++;
      transact(27'h20, 1'b0, 27'h0, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hit !== e.hit || obs_data !== e.data || obs_acc_en !== 1'b0) $display("FAIL swap_new: got hit=%0b acc=%0b data=%0h want %0b/0/%0h", obs_hit, obs_acc_en, obs_data, e.hit, e.data); else n_pass++;
      transact(27'h20, 1'b0, 27'h0, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hit !== e.hit || obs_hit !== 1'b0) $display("FAIL inval_miss: got hit=%0b want 0", obs_hit); else n_pass++;
      transact(27'h6, 1'b1, 27'h30, 1'b1, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hit !== e.hit || obs_dirty !== e.dirty || obs_acc_idx !== 3'd5) $display("FAIL swap_dirty: got hit=%0b dirty=%0b idx=%0d want %0b/%0b/5", obs_hit, obs_dirty, obs_acc_idx, e.hit, e.dirty); else n_pass++;
      transact(27'h300, 1'b1, 27'h21, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hit !== 1'b0 || obs_acc_idx !== 3'd2 || obs_acc_idx !== e.acc_idx) $display("FAIL refill_idx: got hit=%0b idx=%0d want 0/2", obs_hit, obs_acc_idx); else n_pass++;
   endtask

   task automatic test_dirty_wb();
      exp_t e;
      lru_idx = 3'd0;
      transact(27'h500, 1'b1, 27'h41, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_wb_valid !== 1'b0 || obs_wb_valid !== e.wb || obs_acc_idx !== 3'd0) $display("FAIL clean_drop: got wb=%0b idx=%0d want 0/0", obs_wb_valid, obs_acc_idx); else n_pass++;
      lru_idx = 3'd5;
      transact(27'h200, 1'b1, 27'h40, 1'b0, 10, 5);
      e = exp_q.pop_front();
      n_chk++; if (obs_timeout !== 1'b0) $display("FAIL wb_timeout: got %0b want 0", obs_timeout); else n_pass++;
      n_chk++; if (obs_acc_idx !== 3'd5 || obs_hit !== 1'b0) $display("FAIL wb_acc: got idx=%0d hit=%0b want 5/0", obs_acc_idx, obs_hit); else n_pass++;
      n_chk++; if (obs_wb_valid !== 1'b1 || obs_wb_tag !== 27'h30 || obs_wb_tag !== e.wb_tag) $display("FAIL wb_tag: got valid=%0b tag=%0h want 1/30", obs_wb_valid, obs_wb_tag); else n_pass++;
      n_chk++; if (obs_wb_data !== e.wb_data) $display("FAIL wb_data: got %0h want %0h", obs_wb_data, e.wb_data); else n_pass++;
      n_chk++; if (obs_stable !== 1'b1) $display("FAIL stall_stable: got %0b want 1", obs_stable); else n_pass++;
      n_chk++; if (obs_end_ready !== 1'b1) $display("FAIL wb_ready_end: got %0b want 1", obs_end_ready); else n_pass++;
      transact(27'h40, 1'b0, 27'h0, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hit !== 1'b1 || obs_data !== line_of(27'h40) || obs_data !== e.data) $display("FAIL slot5_new: got hit=%0b data=%0h want 1/%0h", obs_hit, obs_data, e.data); else n_pass++;
   endtask

   task automatic test_reset_mid_wb();
      exp_t e;
      lru_idx = 3'd5;
      transact(27'h400, 1'b1, 27'h50, 1'b1, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_acc_idx !== e.acc_idx || obs_wb_valid !== e.wb) $display("FAIL pre_fill: got idx=%0d wb=%0b want %0d/%0b", obs_acc_idx, obs_wb_valid, e.acc_idx, e.wb); else n_pass++;
      transact(27'h401, 1'b1, 27'h60, 1'b0, 0, -1);
      e = exp_q.pop_front();
      n_chk++; if (obs_wb_valid !== 1'b1 || obs_wb_tag !== 27'h50 || obs_wb_tag !== e.wb_tag) $display("FAIL mid_wb_tag: got valid=%0b tag=%0h want 1/50", obs_wb_valid, obs_wb_tag); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_chk++; if (wb_valid !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL mid_wb_rst: got wb=%0b ready=%0b rsp=%0b want 0/0/0", wb_valid, req_ready, rsp_valid); else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1; model_clear();
      transact(27'h41, 1'b0, 27'h0, 1'b0, 0, 0);
      e = exp_q.pop_front();
      n_chk++; if (obs_hit !== 1'b0 || obs_hit !== e.hit || obs_timeout !== 1'b0) $display("FAIL post_rst_miss: got hit=%0b timeout=%0b want 0/0", obs_hit, obs_timeout); else n_pass++;
   endtask

   task automatic test_final();
      n_chk++; if (acc_bad !== 1'b0) $display("FAIL acc_idx_idle: got %0b want 0", acc_bad); else n_pass++;
      n_chk++; if (exp_q.size() !== 0) $display("FAIL sb_empty: got %0d want 0", exp_q.size()); else n_pass++;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_empty_miss();
      test_fill();
      test_hit_swap();
      test_dirty_wb();
      test_reset_mid_wb();
      test_final();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
